u016_cvt_arb: RTL
=================

Name: u016_cvt_arb

Overview:
- Shares one U0.16-to-FP32 conversion datapath between two softmax requester streams, A and B.
- Typical requesters: the exp-value stream and the normalisation/sum stream.
- Arbitrates round-robin at packet granularity. Once a packet is granted, arbitration stays locked until its last beat.
- Registers the converted result in a one-entry valid/ready output stage, tagged with its source and last flag.

Parameters:
- MAX_BEATS, 256: maximum beats per packet before the lock is forcibly released. Range 1..65535.
- CNT_W, 16: width of the beat counter. Must hold MAX_BEATS.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  requester A beat valid
- a_ready  out  1  requester A beat accepted when a_valid & a_ready
- a_data  in  16  requester A U0.16 value
- a_last  in  1  requester A last beat of packet
- b_valid  in  1  requester B beat valid
- b_ready  out  1  requester B beat accepted when b_valid & b_ready
- b_data  in  16  requester B U0.16 value
- b_last  in  1  requester B last beat of packet
- out_valid  out  1  converted beat available
- out_ready  in  1  downstream accepts beat
- out_fp32  out  32  IEEE-754 single result
- out_src  out  1  0 = from A, 1 = from B
- out_last  out  1  packet end (real last or forced release)
- err_overrun  out  1  sticky; set on a forced release, cleared only by rst

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_fp32=0, out_src=0, out_last=0, err_overrun=0.
  - state=IDLE, prio=A, beat_cnt=0.
  - a_ready and b_ready are 0 during the reset cycle.
  - Reset mid-packet discards the packet in progress and any held output beat.
- Output stage advance condition: adv = !out_valid | out_ready.
- States: IDLE, LOCK_A, LOCK_B.
- IDLE:
  - sel = the prio channel if it is valid, else the other channel if valid, else none.
  - The selected channel's ready = adv, so a beat is accepted in the same cycle (no bubble).
  - The unselected channel's ready = 0.
  - On acceptance: if last, or MAX_BEATS==1, stay in IDLE and set prio = the other channel. Otherwise go to LOCK_<sel> with beat_cnt=1.
- LOCK_A / LOCK_B:
  - Only the locked channel sees ready = adv; the other channel's ready = 0, even if it is valid.
  - Each accepted beat increments beat_cnt.
  - An accepted beat with last=1 returns to IDLE, clears beat_cnt, and sets prio = the other channel.
- Forced release: an accepted non-last beat that brings beat_cnt to MAX_BEATS is treated as last:
  - it is emitted with out_last=1;
  - err_overrun is set;
  - the block returns to IDLE and rotates prio.
  - Subsequent beats of that packet re-arbitrate as a new packet.
- Ready must never depend combinationally on the same channel's valid beyond the selection logic above. No combinational path from out_ready to out_valid.
- Conversion (combinational, registered into out_fp32 on acceptance):
  - Input 0 gives 0x00000000.
  - Otherwise, with k = MSB index (0..15): exponent = k+111 and fraction = bits below the MSB, left-aligned and zero-padded to 23 bits. Sign = 0.
  - Exact conversion; no rounding.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Output holding rules:
  - When out_valid=1 and out_ready=0, out_fp32, out_src and out_last hold stable.
  - Both input readys are 0 in this condition.
  - When out_valid=1, out_ready=1 and no input is accepted, out_valid goes to 0 next cycle.
- Simultaneous a_valid and b_valid in IDLE: prio wins. prio after reset = A.
- A valid deassertion mid-packet while locked: the lock is held (the other channel starves until last or forced release).

Test Plan:
- Single beats, out_ready=1:
  - A 0x8000 gives 0x3F000000.
  - A 0x0001 gives 0x37800000.
  - B 0xFFFF gives 0x3F7FFF00.
  - A 0x0000 gives 0x00000000.
  - Each appears 1 cycle after acceptance with the correct out_src.
- Both valid continuously, 1-beat packets (last=1), out_ready=1: out_src alternates A,B,A,B… starting with A after reset.
- A sends a 3-beat packet while B is valid throughout: all 3 A beats precede any B beat. b_ready=0 for those 3 cycles. The B packet follows with no idle cycle.
- Backpressure: out_ready=0 for 4 cycles while out_valid=1: outputs stable, a_ready=b_ready=0. On release, no beat is lost or duplicated (compare against a scoreboard).
- MAX_BEATS=4, A sends 6 beats with last only on the 6th:
  - beat 4 is emitted with out_last=1 and err_overrun=1;
  - B is granted next if valid;
  - err_overrun stays 1 until rst.
- rst asserted mid-packet with out_valid=1: next cycle out_valid=0, state IDLE, prio=A, err_overrun=0. A new B-only packet is accepted immediately.

Source files
------------

// File: rtl/u016_cvt_arb.sv
// Two-stream U0.16 to FP32 converter with packet round-robin arbitration.
// One-entry registered output stage tagged with source and last.
module u016_cvt_arb #(
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [15:0] a_data,
  input  logic        a_last,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [15:0] b_data,
  input  logic        b_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_fp32,
  output logic        out_src,
  output logic        out_last,
  output logic        err_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_A,
    LOCK_B
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [31:0]      fp_q, fp_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             adv;
  logic             sel_a, sel_b;
  logic             acc_a, acc_b, acc;
  logic [15:0]      in_data;
  logic             in_last;
  logic [CNT_W-1:0] cnt_inc;
  logic             forced, rel;
  logic [3:0]       k;
  logic [14:0]      frac;
  logic [31:0]      conv;

  assign out_valid   = ov_q;
  assign out_fp32    = fp_q;
  assign out_src     = src_q;
  assign out_last    = last_q;
  assign err_overrun = err_q;

  // Grant selection: lock owner, else priority channel first
  always_comb begin
    adv   = !ov_q | out_ready;
    sel_a = 1'b0;
    sel_b = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_a = prio_q ? (a_valid & !b_valid) : a_valid;
        sel_b = prio_q ? b_valid : (b_valid & !a_valid);
      end
      LOCK_A: sel_a = 1'b1;
      LOCK_B: sel_b = 1'b1;
      default: ;
    endcase
    a_ready = sel_a & adv & !rst;
    b_ready = sel_b & adv & !rst;
    acc_a   = a_valid & a_ready;
    acc_b   = b_valid & b_ready;
    acc     = acc_a | acc_b;
    in_data = acc_b ? b_data : a_data;
    in_last = acc_b ? b_last : a_last;
  end

  // Exact U0.16 to FP32: leading-one position sets exponent
  always_comb begin
    k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (in_data[i]) k = 4'(i);
    end
    frac = 15'(in_data << (4'd15 - k));
    if (in_data == 16'd0) conv = 32'd0;
    else conv = {1'b0, {4'd0, k} + 8'd111, frac, 8'h00};
  end

  // Beat counting, lock release and output stage next state
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    fp_d    = fp_q;
    src_d   = src_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_inc = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    forced  = !in_last && (cnt_inc == CNT_W'(MAX_BEATS));
    rel     = in_last | forced;
    if (acc) begin
      if (rel) begin
        state_d = IDLE;
        prio_d  = acc_a;
        cnt_d   = '0;
        if (forced) err_d = 1'b1;
      end else begin
        state_d = acc_a ? LOCK_A : LOCK_B;
        cnt_d   = cnt_inc;
      end
      ov_d   = 1'b1;
      fp_d   = conv;
      src_d  = acc_b;
      last_d = rel;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      fp_q    <= 32'd0;
      src_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      fp_q    <= fp_d;
      src_q   <= src_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule
